// File: rtl/imem_loader.sv
// Boot loader: assembles a byte-serial, XOR-checksummed program image into 16-bit
// instruction words, writes them to instruction memory and releases the core on success.
module imem_loader #(
    parameter int n      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [n-1:0]      imem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [7:0]        len_hi_reg, len_hi_next;
    logic [ADDR_W:0]   len_reg, len_next;
    logic [7:0]        hi_reg, hi_next;
    logic [7:0]        csum_reg, csum_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [n-1:0]      wdata_reg, wdata_next;
    logic [ADDR_W:0]   count_reg, count_next;

    logic              xfer;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   count_inc;

    assign in_ready     = (state_reg != S_DONE) && (state_reg != S_ERR);
    assign xfer         = in_valid && in_ready;
    assign len_full     = {len_hi_reg, in_data};
    assign count_inc    = count_reg + ONE;

    assign done         = (state_reg == S_DONE);
    assign err          = (state_reg == S_ERR);
    assign cpu_run      = (state_reg == S_DONE);
    assign imem_we      = we_reg;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;
    assign words_loaded = count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_LEN_HI;
            len_hi_reg <= '0;
            len_reg    <= '0;
            hi_reg     <= '0;
            csum_reg   <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            len_hi_reg <= len_hi_next;
            len_reg    <= len_next;
            hi_reg     <= hi_next;
            csum_reg   <= csum_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        len_hi_next = len_hi_reg;
        len_next    = len_reg;
        hi_next     = hi_reg;
        csum_next   = csum_reg;
        we_next     = 1'b0;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        count_next  = count_reg;

        case (state_reg)
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_next = in_data;
                    csum_next   = csum_reg ^ in_data;
                    state_next  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    csum_next = csum_reg ^ in_data;
                    len_next  = len_full[ADDR_W:0];
                    // Oversized frames are rejected before any memory is touched
                    if ({1'b0, len_full} > MAX_LEN) begin
                        state_next = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_next    = in_data;
                    csum_next  = csum_reg ^ in_data;
                    state_next = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    csum_next  = csum_reg ^ in_data;
                    we_next    = 1'b1;
                    addr_next  = count_reg[ADDR_W-1:0];
                    wdata_next = {hi_reg, in_data};
                    count_next = count_inc;
                    state_next = (count_inc == len_reg) ? S_CSUM : S_DATA_HI;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN_HI;
                    count_next = '0;
                    csum_next  = '0;
                end
            end
            default: state_next = S_LEN_HI;
        endcase
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's 16-bit instruction memory.
- Accepts a byte-serial program image over a valid/ready stream and assembles 16-bit instruction words (3-bit opcode in [15:13]).
- Writes the words into instruction memory, checks an XOR checksum, then releases the CPU core from reset.
- Sits between the host/UART byte interface and the instruction memory write port; the core's fetch/decode path only reads what this block has written.

Parameters:
- n, 16, instruction word width in bits; fixed at 16, high byte sent first.
- ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  re-arm pulse; honoured only in S_DONE or S_ERR
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte; transfer when in_valid && in_ready
- imem_we  output  1  instruction memory write enable, one-cycle pulse
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  n  write data {hi_byte, lo_byte}
- words_loaded  output  ADDR_W+1  count of words written in current frame
- cpu_run  output  1  1 = core released from reset
- done  output  1  frame loaded and checksum good
- err  output  1  frame rejected

Behaviour:
- Reset values (async on reset_n low): state=S_LEN_HI, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, cpu_run=0, done=0, err=0, running checksum=0.
- Frame format: LEN_HI, LEN_LO (16-bit word count L), then L pairs {HI, LO}, then one CSUM byte. CSUM must equal the XOR of every preceding byte in the frame, including the length bytes.
- States:
  - S_LEN_HI: on transfer, store byte → S_LEN_LO.
  - S_LEN_LO: on transfer, L = {stored, byte}.
    - L > 2**ADDR_W → S_ERR; no memory writes occur.
    - L == 0 → S_CSUM.
    - Otherwise → S_DATA_HI.
  - S_DATA_HI: on transfer, store high byte → S_DATA_LO.
  - S_DATA_LO: on transfer, register the write. Next cycle: imem_we=1, imem_addr=words_loaded (old value), imem_wdata={hi, lo}; words_loaded increments in the same cycle. → S_CSUM when this is word L, else → S_DATA_HI.
  - S_CSUM: on transfer, compare the byte to the running XOR.
    - Equal → S_DONE.
    - Else → S_ERR.
  - S_DONE: in_ready=0, done=1, cpu_run=1.
  - S_ERR: in_ready=0, err=1, cpu_run=0.
  - start in S_DONE/S_ERR → S_LEN_HI, and next cycle: done=0, err=0, cpu_run=0, words_loaded=0, checksum=0. start in any other state is ignored.
- Checksum: running XOR updates on every accepted byte from LEN_HI through the last data byte. The CSUM byte itself is not folded in.
- Write timing:
  - imem_we is high exactly one cycle per word.
  - A maximum-rate stream (in_valid held high) produces one write every 2 cycles; no backpressure is needed in the data states.
- in_ready is 1 in all loading states (S_LEN_HI..S_CSUM) and 0 in S_DONE/S_ERR. Bytes offered in S_DONE/S_ERR are not consumed.
- in_valid low stalls the FSM indefinitely; no timeout.
- imem_addr/imem_wdata hold their last value when imem_we=0.
- Reset mid-frame aborts immediately. Partially written memory is not cleared, cpu_run stays 0, and the next byte is treated as LEN_HI.
- L == 2**ADDR_W is legal: the final write goes to address 2**ADDR_W−1 and words_loaded reaches 2**ADDR_W. No address wrap.

Test Plan:
1. Reset, then frame 00 02 | 60 05 | A0 03 | CSUM=00^02^60^05^A0^03=C4 → writes addr0=0x6005, addr1=0xA003. After that: done=1, cpu_run=1, words_loaded=2, err=0, in_ready=0.
2. Same frame with CSUM=C5 → both writes still occur, then err=1, cpu_run=0, done=0.
3. Length 01 01 (257 > 256) → S_ERR right after LEN_LO; zero imem_we pulses, err=1.
4. Frame 00 00 00 (L=0, CSUM=00) → no writes, done=1, cpu_run=1, words_loaded=0.
5. Run scenario 1 with in_valid toggling randomly, then pulse start. Required: identical writes. After start: done=0, cpu_run=0, in_ready=1. A second frame 00 01 20 07 CSUM=26 writes addr0=0x2007, then done=1.
6. Deassert reset_n after the LEN bytes and one data byte → all outputs take reset values asynchronously; a subsequent full frame loads correctly from addr 0.
